// File: rtl/masked_table_loader_pkg.sv
// Shared definitions for the masked S-box table loader.
package masked_table_loader_pkg;

  localparam int unsigned TBL_DEPTH   = 1024;
  localparam int unsigned TBL_AW      = 10;
  localparam int unsigned TBL_DW      = 8;
  localparam int unsigned BRAM_RD_LAT = 2;
  localparam int unsigned CSUM_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    VERIFY,
    DRAIN,
    CHECK
  } ldr_state_t;

endpackage

// File: rtl/masked_table_loader_checksum_acc.sv
// Clearable modular accumulator used for both the write and readback sums.
module table_checksum_acc
  import masked_table_loader_pkg::*;
#(
  parameter int unsigned W  = CSUM_W,
  parameter int unsigned IW = TBL_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          add_en,
  input  logic [IW-1:0] addend,
  output logic [W-1:0]  sum
);

  // Sum wraps mod 2^W; clear has priority over add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + W'(addend);
    end
  end

endmodule

// File: rtl/masked_table_loader.sv
// Streams a table image into BRAM port A, reads it back through port B and
// compares the byte sums of both passes.
module masked_table_loader
  import masked_table_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = TBL_DEPTH,
  parameter int unsigned AW     = TBL_AW,
  parameter int unsigned DW     = TBL_DW,
  parameter int unsigned RD_LAT = BRAM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DW-1:0]     din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              bram_en,
  output logic              bram_wea,
  output logic [AW-1:0]     bram_addra,
  output logic [DW-1:0]     bram_dia,
  output logic [AW-1:0]     bram_addrb,
  input  logic [DW-1:0]     bram_dob,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CSUM_W-1:0] checksum
);

  ldr_state_t          state;
  ldr_state_t          nxt;
  logic [AW-1:0]       wr_cnt;
  logic [AW-1:0]       rd_cnt;
  logic [RD_LAT-1:0]   vpipe;
  logic [CSUM_W-1:0]   rd_sum;
  logic                go;
  logic                kill;
  logic                accept;
  logic                issue;
  logic                last_wr;
  logic                last_rd;
  logic                rd_acc_en;

  // Handshake and control strobes; abort masks din_ready so an aborted
  // cycle never consumes a byte.
  always_comb begin
    go        = (state == IDLE) && start && !abort;
    kill      = abort && (state inside {LOAD, WAIT, VERIFY, DRAIN});
    din_ready = (state == LOAD) && !abort;
    accept    = din_valid && din_ready;
    issue     = (state == VERIFY) && !abort;
    last_wr   = (wr_cnt == AW'(DEPTH - 1));
    last_rd   = (rd_cnt == AW'(DEPTH - 1));
    rd_acc_en = vpipe[RD_LAT-1] && (state inside {VERIFY, DRAIN});
    busy      = (state != IDLE);
    bram_addrb = rd_cnt;
  end

  // Next-state selection.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (go) nxt = LOAD;
      LOAD:    if (abort) nxt = IDLE;
               else if (accept && last_wr) nxt = WAIT;
      WAIT:    nxt = abort ? IDLE : VERIFY;
      VERIFY:  if (abort) nxt = IDLE;
               else if (last_rd) nxt = DRAIN;
      DRAIN:   if (abort) nxt = IDLE;
               else if (vpipe == '0) nxt = CHECK;
      CHECK:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Address counters and the read-valid pipe aligned to BRAM output latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      vpipe  <= '0;
    end else begin
      if (go) begin
        wr_cnt <= '0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + AW'(1);
      end
      if (go) begin
        rd_cnt <= '0;
      end else if (issue) begin
        rd_cnt <= rd_cnt + AW'(1);
      end
      if (go || kill) begin
        vpipe <= '0;
      end else begin
        vpipe <= (vpipe << 1) | RD_LAT'(issue);
      end
    end
  end

  // Registered BRAM port drive; enable stays up through DRAIN so the
  // output register keeps clocking until the last read emerges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bram_en    <= 1'b0;
      bram_wea   <= 1'b0;
      bram_addra <= '0;
      bram_dia   <= '0;
    end else begin
      bram_wea <= accept;
      bram_en  <= accept || (nxt inside {VERIFY, DRAIN});
      if (accept) begin
        bram_addra <= wr_cnt;
        bram_dia   <= din;
      end
    end
  end

  // Sticky status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else if (go) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else if (kill) begin
      done <= 1'b0;
      err  <= 1'b1;
    end else if (state == CHECK) begin
      done <= 1'b1;
      err  <= (rd_sum != checksum);
    end
  end

  table_checksum_acc #(
    .W  (CSUM_W),
    .IW (DW)
  ) u_wr_sum (
    .clk    (clk),
    .rst    (rst),
    .clr    (go),
    .add_en (accept),
    .addend (din),
    .sum    (checksum)
  );

  table_checksum_acc #(
    .W  (CSUM_W),
    .IW (DW)
  ) u_rd_sum (
    .clk    (clk),
    .rst    (rst),
    .clr    (go),
    .add_en (rd_acc_en),
    .addend (bram_dob),
    .sum    (rd_sum)
  );

endmodule

// File: tb/tb_masked_table_loader.sv
// Directed bench for masked_table_loader with a behavioural 2-cycle BRAM.
module tb_masked_table_loader;
  import masked_table_loader_pkg::*;

  localparam int unsigned N = TBL_DEPTH;
  localparam int unsigned DONE_LAT = N + BRAM_RD_LAT + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        bram_en;
  logic        bram_wea;
  logic [9:0]  bram_addra;
  logic [7:0]  bram_dia;
  logic [9:0]  bram_addrb;
  logic [7:0]  bram_dob = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  masked_table_loader #(
    .DEPTH  (N),
    .AW     (TBL_AW),
    .DW     (TBL_DW),
    .RD_LAT (BRAM_RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .bram_en    (bram_en),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dia   (bram_dia),
    .bram_addrb (bram_addrb),
    .bram_dob   (bram_dob),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  function automatic logic [7:0] img(input int unsigned i);
    return 8'(i) ^ 8'hA5;
  endfunction

  // BRAM model: array read at edge 1, output register at edge 2.
  logic [7:0] mem [0:N-1];
  logic [7:0] lat_q = '0;
  bit         corrupt = 1'b0;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_wea)
        mem[bram_addra] <= bram_dia ^ {7'd0, (corrupt && bram_addra == 10'h155)};
      lat_q    <= mem[bram_addrb];
      bram_dob <= lat_q;
    end
  end

  // Edge counter, last-accept edge and write-sequence monitor.
  int unsigned cyc = 0;
  int unsigned last_acc_edge = 0;
  int unsigned wr_seen = 0;
  int unsigned wr_bad = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (din_valid && din_ready) last_acc_edge <= cyc + 1;
    if (start && !busy) begin
      wr_seen <= 0;
      wr_bad  <= 0;
    end else if (bram_en && bram_wea) begin
      if (bram_addra != 10'(wr_seen) || bram_dia != img(wr_seen)) wr_bad <= wr_bad + 1;
      wr_seen <= wr_seen + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: din_valid always high; mode 1: ~1-in-3 valid.
  // abort_at >= 0 aborts once that many bytes were accepted.
  task automatic run_load(input int mode, input int abort_at, input bit poke_start,
                          input bit exp_err, input string tag);
    int unsigned idx = 0;
    int unsigned n = 0;
    int unsigned t;
    int unsigned mism = 0;
    logic [15:0] psum = '0;
    logic [7:0]  ev;
    bit acc;
    bit seen = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_clr"}, 32'({done, err}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (idx < N && n < 8000) begin
      if (abort_at >= 0 && idx == int'(abort_at)) break;
      din = img(idx);
      din_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      #1 acc = din_valid && din_ready;
      @(negedge clk);
      if (acc) idx++;
      n++;
    end
    din_valid = 1'b0;
    if (abort_at >= 0) begin
      for (int unsigned i = 0; i < idx; i++) psum = psum + 16'(img(i));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd1);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_rdy"}, 32'(din_ready), 32'd0);
      check({tag, "_psum"}, 32'(checksum), 32'(psum));
      return;
    end
    check({tag, "_accepted"}, idx, N);
    for (int k = 0; k < 3000; k++) begin
      start = (poke_start && k == 200);
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(seen), 32'd1);
    t = cyc - last_acc_edge;
    check({tag, "_lat"}, t, DONE_LAT);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_csum"}, 32'(checksum), 32'h0000FE00);
    check({tag, "_nwr"}, wr_seen, N);
    check({tag, "_wrseq"}, wr_bad, 0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    for (int unsigned i = 0; i < N; i++) begin
      ev = img(i) ^ {7'd0, (corrupt && i == 32'h155)};
      if (mem[i] !== ev) mism++;
    end
    check({tag, "_mem"}, mism, 0);
  endtask

  initial begin
    // Reset with random inputs toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      abort = 1'($urandom);
      din = 8'($urandom);
      din_valid = 1'($urandom);
    end
    #1;
    check("rst_flags", 32'({busy, done, err, din_ready, bram_en, bram_wea}), 32'd0);
    check("rst_addra", 32'(bram_addra), 32'd0);
    check("rst_dia", 32'(bram_dia), 32'd0);
    check("rst_addrb", 32'(bram_addrb), 32'd0);
    check("rst_csum", 32'(checksum), 32'd0);
    start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rel_flags", 32'({busy, done, err, din_ready}), 32'd0);

    run_load(0, -1, 1'b0, 1'b0, "full");
    run_load(1, -1, 1'b0, 1'b0, "bp");
    corrupt = 1'b1;
    run_load(0, -1, 1'b0, 1'b1, "corrupt");
    corrupt = 1'b0;
    run_load(0, 300, 1'b0, 1'b0, "abort");
    run_load(0, -1, 1'b0, 1'b0, "reload");
    run_load(0, -1, 1'b1, 1'b0, "bstart");

    // Abort while idle must leave the sticky flags untouched.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("idle_abort", 32'({busy, done, err}), 32'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
